// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one WIDTH-bit adder among NUM_REQ requesters, 1-cycle registered result.
// Optional build macro ADDER_ARB_SAT_EN saturates the sum to all ones on overflow.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             carry;
        logic [WIDTH-1:0] sum;
    } rsp_t;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  hi_g, lo_g, g;
    logic             hi_found, lo_found, any;
    logic [WIDTH-1:0] hi_a, hi_b, lo_a, lo_b, op_a, op_b;
    logic [WIDTH:0]   raw_sum;
    logic             can_accept, accept;
    rsp_t             rsp_q, rsp_d;

    // Two priority scans: indices at/above ptr win over the wrapped ones below it.
    // The descending loop leaves the lowest set index in each half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_g     = '0;
        lo_g     = '0;
        hi_a     = '0;
        hi_b     = '0;
        lo_a     = '0;
        lo_b     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_g     = ID_W'(i);
                    hi_a     = req_in0[i*WIDTH +: WIDTH];
                    hi_b     = req_in1[i*WIDTH +: WIDTH];
                end else begin
                    lo_found = 1'b1;
                    lo_g     = ID_W'(i);
                    lo_a     = req_in0[i*WIDTH +: WIDTH];
                    lo_b     = req_in1[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign any     = hi_found | lo_found;
    assign g       = hi_found ? hi_g : lo_g;
    assign op_a    = hi_found ? hi_a : lo_a;
    assign op_b    = hi_found ? hi_b : lo_b;
    assign ptr_nxt = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;

    // Gating with rst keeps every handshake closed while reset is held.
    assign can_accept = (~rsp_valid | rsp_ready) & ~rst;
    assign accept     = any & can_accept;
    assign req_ready  = accept ? (NUM_REQ'(1) << g) : '0;

    assign raw_sum = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        rsp_d.id    = g;
        rsp_d.carry = raw_sum[WIDTH];
`ifdef ADDER_ARB_SAT_EN
        rsp_d.sum   = raw_sum[WIDTH] ? {WIDTH{1'b1}} : raw_sum[WIDTH-1:0];
`else
        rsp_d.sum   = raw_sum[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            ptr       <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_q     <= rsp_d;
            ptr       <= ptr_nxt;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_id    = rsp_q.id;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_carry = rsp_q.carry;
endmodule
